// File: rtl/ram_portb_arbiter.sv
// ram_portb_arbiter
// -----------------
// Shares port B of a dual-port RAM between a VGA reader and two sample
// writers (EMG and ECG). A free-running tick counter samples one channel
// per tick, alternating EMG/ECG. Each sample waits in a per-channel pending
// register until it is granted a RAM write cycle. VGA reads normally have
// priority over pending writes. A write that has waited STALL_MAX cycles
// is forced through ahead of VGA. Each channel writes into its own ring
// buffer of DEPTH words.
//
// Ports
//   clock, reset          system clock, asynchronous active-high reset
//   emg_in, ecg_in        live ADC words, sampled on the channel's tick
//   vga_req, vga_addr     VGA read request (level) and word address
//   vga_gnt               read granted this cycle (combinational)
//   vga_valid, vga_data   read data for the read granted last cycle
//   ram_wen/addr/din      RAM port B controls (combinational)
//   ram_dout              RAM port B read data, 1-cycle latency
//   emg_wptr, ecg_wptr    next write index of each ring buffer
//   overrun               sticky: a sample was overwritten before written
module ram_portb_arbiter #(
    parameter int          SAMPLE_INTERVAL = 125000,
    parameter int          DEPTH           = 640,
    parameter logic [11:0] EMG_BASE        = 12'h400,
    parameter logic [11:0] ECG_BASE        = 12'h800,
    parameter int          STALL_MAX       = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] emg_in,
    input  logic [31:0] ecg_in,
    input  logic        vga_req,
    input  logic [11:0] vga_addr,
    output logic        vga_gnt,
    output logic        vga_valid,
    output logic [31:0] vga_data,
    output logic        ram_wen,
    output logic [11:0] ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout,
    output logic [9:0]  emg_wptr,
    output logic [9:0]  ecg_wptr,
    output logic        overrun
);

    localparam int CNT_W  = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL) : 1;
    localparam int WAIT_W = $clog2(STALL_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(SAMPLE_INTERVAL - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(STALL_MAX);
    localparam logic [9:0]        WPTR_LAST  = 10'(DEPTH - 1);

    // Port B owner for the current cycle
    localparam logic [1:0] GNT_IDLE = 2'd0;
    localparam logic [1:0] GNT_VGA  = 2'd1;
    localparam logic [1:0] GNT_EMG  = 2'd2;
    localparam logic [1:0] GNT_ECG  = 2'd3;

    // ------------------------------------------------------------------
    // Tick generator and channel select (0 = EMG, 1 = ECG)
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             tick;

    assign tick  = (cnt_q == CNT_LAST);
    assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    assign sel_d = sel_q ^ tick;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            sel_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel pending write state (index 0 = EMG, 1 = ECG)
    // ------------------------------------------------------------------
    logic [1:0]  pend_w;
    logic [1:0]  force_w;
    logic [1:0]  wr_gnt;
    logic [1:0]  drop_w;
    logic [31:0] data_w  [2];
    logic [11:0] waddr_w [2];
    logic [9:0]  wptr_w  [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        localparam logic        CH_SEL = 1'(gi);
        localparam logic [11:0] BASE   = (gi == 0) ? EMG_BASE : ECG_BASE;

        logic              pend_q, pend_d;
        logic [31:0]       data_q, data_d;
        logic [WAIT_W-1:0] wait_q, wait_d;
        logic [9:0]        wptr_q, wptr_d;
        logic              tick_here;
        logic [31:0]       sample;

        assign sample    = (gi == 0) ? emg_in : ecg_in;
        assign tick_here = tick && (sel_q == CH_SEL);

        always_comb begin
            pend_d = pend_q;
            data_d = data_q;
            wptr_d = wptr_q;
            if (wr_gnt[gi]) begin
                pend_d = 1'b0;
                wptr_d = (wptr_q == WPTR_LAST) ? 10'd0 : wptr_q + 10'd1;
            end
            // A tick on the same edge as this channel's write reloads the
            // register behind the write, so the new sample stays pending.
            if (tick_here) begin
                pend_d = 1'b1;
                data_d = sample;
            end
            // The wait count restarts whenever the register is emptied or
            // written out; an overwrite of a waiting sample keeps counting.
            if (!pend_q || wr_gnt[gi]) begin
                wait_d = '0;
            end else if (wait_q != WAIT_LIMIT) begin
                wait_d = wait_q + WAIT_W'(1);
            end else begin
                wait_d = wait_q;
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                pend_q <= 1'b0;
                data_q <= '0;
                wait_q <= '0;
                wptr_q <= '0;
            end else begin
                pend_q <= pend_d;
                data_q <= data_d;
                wait_q <= wait_d;
                wptr_q <= wptr_d;
            end
        end

        assign pend_w[gi]  = pend_q;
        assign force_w[gi] = pend_q && (wait_q == WAIT_LIMIT);
        assign drop_w[gi]  = tick_here && pend_q && !wr_gnt[gi];
        assign data_w[gi]  = data_q;
        assign waddr_w[gi] = BASE + {2'b00, wptr_q};
        assign wptr_w[gi]  = wptr_q;
    end

    // ------------------------------------------------------------------
    // Port B arbitration
    // ------------------------------------------------------------------
    logic [1:0] gnt_sel;

    always_comb begin
        gnt_sel = GNT_IDLE;
        if (force_w[0]) begin
            gnt_sel = GNT_EMG;
        end else if (force_w[1]) begin
            gnt_sel = GNT_ECG;
        end else if (vga_req) begin
            gnt_sel = GNT_VGA;
        end else if (pend_w[0]) begin
            gnt_sel = GNT_EMG;
        end else if (pend_w[1]) begin
            gnt_sel = GNT_ECG;
        end
    end

    assign wr_gnt[0] = (gnt_sel == GNT_EMG);
    assign wr_gnt[1] = (gnt_sel == GNT_ECG);
    assign vga_gnt   = (gnt_sel == GNT_VGA);
    assign ram_wen   = |wr_gnt;

    always_comb begin
        ram_addr = vga_addr;
        ram_din  = '0;
        if (wr_gnt[0]) begin
            ram_addr = waddr_w[0];
            ram_din  = data_w[0];
        end else if (wr_gnt[1]) begin
            ram_addr = waddr_w[1];
            ram_din  = data_w[1];
        end
    end

    // ------------------------------------------------------------------
    // Read-valid pipeline and sticky overrun
    // ------------------------------------------------------------------
    logic vga_valid_q;
    logic overrun_q, overrun_d;

    assign overrun_d = overrun_q | (|drop_w);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vga_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            vga_valid_q <= vga_gnt;
            overrun_q   <= overrun_d;
        end
    end

    assign vga_valid = vga_valid_q;
    assign vga_data  = ram_dout;
    assign emg_wptr  = wptr_w[0];
    assign ecg_wptr  = wptr_w[1];
    assign overrun   = overrun_q;

endmodule
